// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: IO base, length codes,
// FSM encodings and small byte-lane helpers.
package mem_ctrl_pkg;

  localparam logic [31:0] MC_IO_BASE = 32'h0003_0000;

  localparam logic [2:0] MC_LEN_B = 3'd1;
  localparam logic [2:0] MC_LEN_H = 3'd2;
  localparam logic [2:0] MC_LEN_W = 3'd4;

  localparam logic [1:0] MC_S_IDLE = 2'd0;
  localparam logic [1:0] MC_S_BUSY = 2'd1;
  localparam logic [1:0] MC_S_TAIL = 2'd2;

  localparam logic MC_PORT_IF  = 1'b0;
  localparam logic MC_PORT_LSB = 1'b1;

  // Index of the final byte of a request; unknown length codes act as a word.
  function automatic logic [1:0] mc_last_idx(input logic [2:0] len);
    case (len)
      MC_LEN_B: return 2'd0;
      MC_LEN_H: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] mc_get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] mc_put_byte(input logic [31:0] word, input logic [1:0] idx,
                                              input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch vs load/store, serializes 1/2/4-byte requests onto a byte-wide
// RAM with 1-cycle read latency, and returns little-endian data with a done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = MC_IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_w_data,
  output logic        lsb_done,
  output logic [31:0] lsb_r_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  recv_cnt_q, recv_cnt_d;
  logic [1:0]  last_q, last_d;
  logic        port_q, port_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [31:0] r_data_q, r_data_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;

  logic stall;
  logic issuing;
  logic lsb_ok;
  logic if_ok;

  always_comb begin
    stall   = (state_q == MC_S_BUSY) && wr_q && (addr_q >= IO_BASE) && io_buffer_full;
    issuing = (state_q == MC_S_BUSY) && !stall;
    // Reads are blocked by a flush at acceptance; committed stores are not.
    lsb_ok  = lsb_en && !lsb_done_q && (lsb_wr || !rollback);
    if_ok   = if_en && !if_done_q && !rollback;
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    last_d      = last_q;
    port_d      = port_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    w_data_d    = w_data_q;
    r_data_d    = r_data_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;

    case (state_q)
      MC_S_IDLE: begin
        if (lsb_ok) begin
          state_d     = MC_S_BUSY;
          port_d      = MC_PORT_LSB;
          wr_d        = lsb_wr;
          addr_d      = lsb_addr;
          last_d      = mc_last_idx(lsb_len);
          w_data_d    = lsb_w_data;
          r_data_d    = '0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end else if (if_ok) begin
          state_d     = MC_S_BUSY;
          port_d      = MC_PORT_IF;
          wr_d        = 1'b0;
          addr_d      = if_addr;
          last_d      = mc_last_idx(MC_LEN_W);
          w_data_d    = '0;
          r_data_d    = '0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end

      MC_S_BUSY: begin
        if (rollback && !wr_q) begin
          state_d     = MC_S_IDLE;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end else if (issuing) begin
          // The byte addressed last cycle is on mem_din now.
          if (!wr_q && (issue_cnt_q != 2'd0)) begin
            r_data_d   = mc_put_byte(r_data_q, recv_cnt_q, mem_din);
            recv_cnt_d = recv_cnt_q + 2'd1;
          end
          issue_cnt_d = issue_cnt_q + 2'd1;
          if (issue_cnt_q == last_q) begin
            if (wr_q) begin
              state_d     = MC_S_IDLE;
              issue_cnt_d = '0;
              recv_cnt_d  = '0;
              lsb_done_d  = 1'b1;
            end else begin
              state_d = MC_S_TAIL;
            end
          end
        end
      end

      MC_S_TAIL: begin
        state_d     = MC_S_IDLE;
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        if (!rollback) begin
          r_data_d = mc_put_byte(r_data_q, recv_cnt_q, mem_din);
          if (port_q == MC_PORT_LSB) lsb_done_d = 1'b1;
          else                       if_done_d  = 1'b1;
        end
      end

      default: begin
        state_d     = MC_S_IDLE;
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_S_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      last_q      <= '0;
      port_q      <= MC_PORT_IF;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      w_data_q    <= '0;
      r_data_q    <= '0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      last_q      <= last_d;
      port_q      <= port_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      w_data_q    <= w_data_d;
      r_data_q    <= r_data_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
    end
  end

  always_comb begin
    mem_a      = issuing ? (addr_q + {30'd0, issue_cnt_q}) : '0;
    mem_wr     = issuing && wr_q;
    mem_dout   = (issuing && wr_q) ? mc_get_byte(w_data_q, issue_cnt_q) : '0;
    if_done    = if_done_q;
    lsb_done   = lsb_done_q;
    if_data    = if_done_q  ? r_data_q : '0;
    lsb_r_data = lsb_done_q ? r_data_q : '0;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 4 KiB byte RAM model (1-cycle read latency).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_en, lsb_wr;
  logic [31:0] lsb_addr;
  logic [2:0]  lsb_len;
  logic [31:0] lsb_w_data;
  logic        lsb_done;
  logic [31:0] lsb_r_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] ram [0:4095];

  mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM contents are (re)loaded while reset is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22;
      ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
      ram[12'h040] <= 8'hA1; ram[12'h041] <= 8'hB2;
      ram[12'h042] <= 8'hC3; ram[12'h043] <= 8'hD4;
      ram[12'h202] <= 8'h77;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'h0);
    chk({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'h0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_quiet(tag);
    chk({tag, "_if_done"}, {31'd0, if_done}, 32'h0);
    chk({tag, "_lsb_done"}, {31'd0, lsb_done}, 32'h0);
    chk({tag, "_if_data"}, if_data, 32'h0);
    chk({tag, "_lsb_r_data"}, lsb_r_data, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    if_en = 1'b0; if_addr = '0;
    lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
    io_buffer_full = 1'b0;
    nxt(); nxt();
    chk_outputs_zero("reset");
    rst = 1'b0;
    nxt();

    // Word load at 0x100
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4;
    nxt(); chk("rd_c1_a", mem_a, 32'h100); chk("rd_c1_wr", {31'd0, mem_wr}, 32'h0);
    nxt(); chk("rd_c2_a", mem_a, 32'h101);
    nxt(); chk("rd_c3_a", mem_a, 32'h102);
    nxt(); chk("rd_c4_a", mem_a, 32'h103);
    nxt(); chk("rd_c5_a", mem_a, 32'h0); chk("rd_c5_done", {31'd0, lsb_done}, 32'h0);
    nxt(); chk("rd_c6_done", {31'd0, lsb_done}, 32'h1);
    chk("rd_c6_data", lsb_r_data, 32'h4433_2211);
    lsb_en = 1'b0;
    nxt(); chk("rd_c7_done", {31'd0, lsb_done}, 32'h0); chk("rd_c7_data", lsb_r_data, 32'h0);

    // Half store at 0x200
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h200; lsb_len = 3'd2; lsb_w_data = 32'hAABB_CCDD;
    nxt(); chk("wr_c1_wr", {31'd0, mem_wr}, 32'h1); chk("wr_c1_a", mem_a, 32'h200);
    chk("wr_c1_dout", {24'd0, mem_dout}, 32'hDD);
    nxt(); chk("wr_c2_wr", {31'd0, mem_wr}, 32'h1); chk("wr_c2_a", mem_a, 32'h201);
    chk("wr_c2_dout", {24'd0, mem_dout}, 32'hCC);
    nxt(); chk("wr_c3_done", {31'd0, lsb_done}, 32'h1); chk("wr_c3_wr", {31'd0, mem_wr}, 32'h0);
    lsb_en = 1'b0; lsb_wr = 1'b0;
    nxt();
    chk("wr_ram200", {24'd0, ram[12'h200]}, 32'hDD);
    chk("wr_ram201", {24'd0, ram[12'h201]}, 32'hCC);
    chk("wr_ram202", {24'd0, ram[12'h202]}, 32'h77);

    // Simultaneous requests: byte load wins, fetch follows in the done cycle
    if_en = 1'b1; if_addr = 32'h40;
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h101; lsb_len = 3'd1;
    nxt(); chk("arb_c1_a", mem_a, 32'h101);
    nxt(); chk("arb_c2_a", mem_a, 32'h0);
    nxt(); chk("arb_c3_lsb_done", {31'd0, lsb_done}, 32'h1);
    chk("arb_c3_lsb_data", lsb_r_data, 32'h22);
    chk("arb_c3_if_done", {31'd0, if_done}, 32'h0);
    lsb_en = 1'b0;
    nxt(); chk("arb_c4_a", mem_a, 32'h40);
    nxt(); nxt();
    nxt(); chk("arb_c7_a", mem_a, 32'h43);
    nxt(); chk("arb_c8_if_done", {31'd0, if_done}, 32'h0);
    nxt(); chk("arb_c9_if_done", {31'd0, if_done}, 32'h1);
    chk("arb_c9_if_data", if_data, 32'hD4C3_B2A1);
    if_en = 1'b0;
    nxt(); chk("arb_c10_if_done", {31'd0, if_done}, 32'h0);

    // IO store stalled by a full IO buffer
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0004; lsb_len = 3'd1; lsb_w_data = 32'h0000_00E7;
    nxt(); io_buffer_full = 1'b1; #1; chk_quiet("io_c1");
    nxt(); chk_quiet("io_c2");
    nxt(); chk_quiet("io_c3"); chk("io_c3_done", {31'd0, lsb_done}, 32'h0);
    nxt(); io_buffer_full = 1'b0; #1;
    chk("io_c4_wr", {31'd0, mem_wr}, 32'h1); chk("io_c4_a", mem_a, 32'h0003_0004);
    chk("io_c4_dout", {24'd0, mem_dout}, 32'hE7);
    nxt(); chk("io_c5_done", {31'd0, lsb_done}, 32'h1);
    lsb_en = 1'b0; lsb_wr = 1'b0;
    nxt(); chk("io_ram", {24'd0, ram[12'h004]}, 32'hE7);

    // Rollback aborts a fetch in its third cycle
    if_en = 1'b1; if_addr = 32'h40;
    nxt(); chk("rbf_c1_a", mem_a, 32'h40);
    nxt();
    nxt(); rollback = 1'b1; if_en = 1'b0; chk("rbf_c3_a", mem_a, 32'h42);
    nxt(); rollback = 1'b0; #1;
    chk("rbf_c4_a", mem_a, 32'h0); chk("rbf_c4_if_done", {31'd0, if_done}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      nxt(); chk("rbf_no_done", {31'd0, if_done}, 32'h0);
    end

    // Rollback does not disturb a store
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h210; lsb_len = 3'd4; lsb_w_data = 32'h0102_0304;
    nxt(); chk("rbw_c1_dout", {24'd0, mem_dout}, 32'h04);
    nxt(); rollback = 1'b1; chk("rbw_c2_a", mem_a, 32'h211);
    nxt(); chk("rbw_c3_dout", {24'd0, mem_dout}, 32'h02);
    nxt(); chk("rbw_c4_a", mem_a, 32'h213); chk("rbw_c4_wr", {31'd0, mem_wr}, 32'h1);
    nxt(); rollback = 1'b0; chk("rbw_c5_done", {31'd0, lsb_done}, 32'h1);
    lsb_en = 1'b0; lsb_wr = 1'b0;
    nxt(); chk("rbw_c6_done", {31'd0, lsb_done}, 32'h0);

    // Reset in the middle of a word load
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4;
    nxt(); chk("rst_c1_a", mem_a, 32'h100);
    nxt(); rst = 1'b1; lsb_en = 1'b0;
    nxt(); rst = 1'b0; chk_outputs_zero("rst_c3");
    for (int i = 0; i < 8; i++) begin
      nxt(); chk("rst_no_done", {31'd0, lsb_done}, 32'h0);
    end

    // rdy low freezes the engine and holds the done pulse
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h103; lsb_len = 3'd1;
    nxt(); chk("rdy_c1_a", mem_a, 32'h103); rdy = 1'b0;
    nxt(); chk("rdy_c2_a", mem_a, 32'h103);
    nxt(); chk("rdy_c3_a", mem_a, 32'h103); rdy = 1'b1;
    nxt(); chk("rdy_c4_a", mem_a, 32'h0);
    nxt(); chk("rdy_c5_done", {31'd0, lsb_done}, 32'h1); chk("rdy_c5_data", lsb_r_data, 32'h44);
    rdy = 1'b0; lsb_en = 1'b0;
    nxt(); chk("rdy_c6_done_held", {31'd0, lsb_done}, 32'h1); rdy = 1'b1;
    nxt(); chk("rdy_c7_done", {31'd0, lsb_done}, 32'h0);

    // Half load is zero-extended
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h102; lsb_len = 3'd2;
    nxt(); nxt(); chk("h_c2_a", mem_a, 32'h103);
    nxt(); chk("h_c3_done", {31'd0, lsb_done}, 32'h0);
    nxt(); chk("h_c4_done", {31'd0, lsb_done}, 32'h1); chk("h_c4_data", lsb_r_data, 32'h0000_4433);
    lsb_en = 1'b0;
    nxt();

    // Address wraps past 0xFFFFFFFF
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'hFFFF_FFFF; lsb_len = 3'd2; lsb_w_data = 32'h0000_BEEF;
    nxt(); chk("wrap_c1_a", mem_a, 32'hFFFF_FFFF); chk("wrap_c1_dout", {24'd0, mem_dout}, 32'hEF);
    nxt(); chk("wrap_c2_a", mem_a, 32'h0); chk("wrap_c2_wr", {31'd0, mem_wr}, 32'h1);
    chk("wrap_c2_dout", {24'd0, mem_dout}, 32'hBE);
    nxt(); chk("wrap_c3_done", {31'd0, lsb_done}, 32'h1);
    lsb_en = 1'b0; lsb_wr = 1'b0;
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
